// File: rtl/rv32i_types.sv
// Shared RV32I decode types: opcodes, control bundles and the ID/EX packet.
// All-zero encodings are the "no operation" defaults used for unknown opcodes.
package rv32i_types;

  localparam int ORDER_W_MAX = 64;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011
  } rv32i_opcode_t;

  typedef enum logic [2:0] {
    f3_add  = 3'd0,
    f3_sll  = 3'd1,
    f3_slt  = 3'd2,
    f3_sltu = 3'd3,
    f3_xor  = 3'd4,
    f3_sr   = 3'd5,
    f3_or   = 3'd6,
    f3_and  = 3'd7
  } arith_f3_t;

  typedef enum logic [2:0] {
    f3_lb  = 3'd0,
    f3_lh  = 3'd1,
    f3_lw  = 3'd2,
    f3_lbu = 3'd4,
    f3_lhu = 3'd5
  } load_f3_t;

  typedef enum logic [2:0] {
    alu_add = 3'd0,
    alu_sll = 3'd1,
    alu_sra = 3'd2,
    alu_sub = 3'd3,
    alu_xor = 3'd4,
    alu_srl = 3'd5,
    alu_or  = 3'd6,
    alu_and = 3'd7
  } alu_ops_t;

  typedef enum logic [2:0] {
    cmp_beq  = 3'd0,
    cmp_bne  = 3'd1,
    cmp_blt  = 3'd4,
    cmp_bge  = 3'd5,
    cmp_bltu = 3'd6,
    cmp_bgeu = 3'd7
  } cmp_ops_t;

  typedef enum logic [1:0] {m1_rs1, m1_pc, m1_zero} alu_m1_sel_t;
  typedef enum logic {m2_imm, m2_rs2} alu_m2_sel_t;
  typedef enum logic [2:0] {imm_none, imm_i, imm_s, imm_b, imm_u, imm_j} imm_sel_t;

  typedef enum logic [3:0] {
    wb_none, wb_alu, wb_ext_br, wb_pc4, wb_lb, wb_lh, wb_lw, wb_lbu, wb_lhu
  } wb_sel_t;

  typedef struct packed {
    alu_ops_t    aluop;
    cmp_ops_t    cmpop;
    alu_m1_sel_t alu_m1_sel;
    alu_m2_sel_t alu_m2_sel;
    imm_sel_t    imm_sel;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
  } ex_ctrl_t;

  typedef struct packed {
    logic       mem_re;
    logic       mem_we;
    logic [2:0] mem_funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic    regf_we;
    wb_sel_t wb_sel;
  } wb_ctrl_t;

  typedef struct packed {
    logic                   valid_s;
    logic [31:0]            inst;
    logic [31:0]            pc;
    logic [31:0]            pc_next;
    logic [ORDER_W_MAX-1:0] order;
    logic [4:0]             rs1_s_s;
    logic [4:0]             rs2_s_s;
    logic [4:0]             rd_s_s;
    logic [31:0]            i_imm_s;
    logic [31:0]            s_imm_s;
    logic [31:0]            b_imm_s;
    logic [31:0]            u_imm_s;
    logic [31:0]            j_imm_s;
    ex_ctrl_t               ex;
    mem_ctrl_t              mem;
    wb_ctrl_t               wb;
  } id_ex_stage_reg_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and EX-side handshake bundle of the decode queue.
interface decode_queue_if #(
  parameter int ORDER_W = 64
);
  import rv32i_types::*;

  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_inst;
  logic [31:0]        in_pc;
  logic [31:0]        in_pc_next;
  logic [ORDER_W-1:0] in_order;
  logic               out_valid;
  logic               out_ready;
  id_ex_stage_reg_t   out_pkt;
  logic [4:0]         out_rs1_s;
  logic [4:0]         out_rs2_s;

  modport master (
    output in_valid, in_inst, in_pc, in_pc_next, in_order, out_ready,
    input  in_ready, out_valid, out_pkt, out_rs1_s, out_rs2_s
  );

  modport slave (
    input  in_valid, in_inst, in_pc, in_pc_next, in_order, out_ready,
    output in_ready, out_valid, out_pkt, out_rs1_s, out_rs2_s
  );

endinterface

// File: rtl/rv32i_decoder.sv
// Pure combinational RV32I decode of one instruction word into an ID/EX packet.
module rv32i_decoder
  import rv32i_types::*;
(
  input  logic [31:0]            inst,
  input  logic [31:0]            pc,
  input  logic [31:0]            pc_next,
  input  logic [ORDER_W_MAX-1:0] order,
  output id_ex_stage_reg_t       pkt
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_reg;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7_5 = inst[30];
  assign is_reg   = (opcode == op_reg);

  always_comb begin
    pkt         = '0;
    pkt.valid_s = 1'b1;
    pkt.inst    = inst;
    pkt.pc      = pc;
    pkt.pc_next = pc_next;
    pkt.order   = order;
    pkt.i_imm_s = {{20{inst[31]}}, inst[31:20]};
    pkt.s_imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    pkt.b_imm_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    pkt.u_imm_s = {inst[31:12], 12'h000};
    pkt.j_imm_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    case (opcode)
      op_lui, op_auipc: begin
        pkt.rd_s_s        = inst[11:7];
        pkt.ex.alu_m1_sel = (opcode == op_lui) ? m1_zero : m1_pc;
        pkt.ex.imm_sel    = imm_u;
        pkt.wb.wb_sel     = wb_alu;
      end
      op_jal: begin
        pkt.rd_s_s        = inst[11:7];
        pkt.ex.alu_m1_sel = m1_pc;
        pkt.ex.imm_sel    = imm_j;
        pkt.ex.is_jal     = 1'b1;
        pkt.wb.wb_sel     = wb_pc4;
      end
      op_jalr: begin
        pkt.rs1_s_s    = inst[19:15];
        pkt.rd_s_s     = inst[11:7];
        pkt.ex.imm_sel = imm_i;
        pkt.ex.is_jalr = 1'b1;
        pkt.wb.wb_sel  = wb_pc4;
      end
      op_br: begin
        pkt.rs1_s_s       = inst[19:15];
        pkt.rs2_s_s       = inst[24:20];
        pkt.ex.alu_m1_sel = m1_pc;
        pkt.ex.imm_sel    = imm_b;
        pkt.ex.is_branch  = 1'b1;
        case (funct3)
          3'd1:    pkt.ex.cmpop = cmp_bne;
          3'd4:    pkt.ex.cmpop = cmp_blt;
          3'd5:    pkt.ex.cmpop = cmp_bge;
          3'd6:    pkt.ex.cmpop = cmp_bltu;
          3'd7:    pkt.ex.cmpop = cmp_bgeu;
          default: pkt.ex.cmpop = cmp_beq;
        endcase
      end
      op_load: begin
        pkt.rs1_s_s        = inst[19:15];
        pkt.rd_s_s         = inst[11:7];
        pkt.ex.imm_sel     = imm_i;
        pkt.mem.mem_re     = 1'b1;
        pkt.mem.mem_funct3 = funct3;
        case (funct3)
          f3_lb:   pkt.wb.wb_sel = wb_lb;
          f3_lh:   pkt.wb.wb_sel = wb_lh;
          f3_lw:   pkt.wb.wb_sel = wb_lw;
          f3_lbu:  pkt.wb.wb_sel = wb_lbu;
          f3_lhu:  pkt.wb.wb_sel = wb_lhu;
          default: pkt.wb.wb_sel = wb_none;
        endcase
      end
      op_store: begin
        pkt.rs1_s_s        = inst[19:15];
        pkt.rs2_s_s        = inst[24:20];
        pkt.ex.imm_sel     = imm_s;
        pkt.mem.mem_we     = 1'b1;
        pkt.mem.mem_funct3 = funct3;
      end
      op_imm, op_reg: begin
        pkt.rs1_s_s   = inst[19:15];
        pkt.rd_s_s    = inst[11:7];
        pkt.wb.wb_sel = wb_alu;
        if (is_reg) begin
          pkt.rs2_s_s       = inst[24:20];
          pkt.ex.alu_m2_sel = m2_rs2;
        end else begin
          pkt.ex.imm_sel = imm_i;
        end
        // funct7[5] is an immediate bit for addi, so only op uses it to pick sub
        case (arith_f3_t'(funct3))
          f3_add:  pkt.ex.aluop = (is_reg && funct7_5) ? alu_sub : alu_add;
          f3_sll:  pkt.ex.aluop = alu_sll;
          f3_slt: begin
            pkt.ex.cmpop  = cmp_blt;
            pkt.wb.wb_sel = wb_ext_br;
          end
          f3_sltu: begin
            pkt.ex.cmpop  = cmp_bltu;
            pkt.wb.wb_sel = wb_ext_br;
          end
          f3_xor:  pkt.ex.aluop = alu_xor;
          f3_sr:   pkt.ex.aluop = funct7_5 ? alu_sra : alu_srl;
          f3_or:   pkt.ex.aluop = alu_or;
          f3_and:  pkt.ex.aluop = alu_and;
          default: pkt.ex.aluop = alu_add;
        endcase
      end
      default: begin
      end
    endcase

    pkt.wb.regf_we = (pkt.rd_s_s != 5'd0) && (pkt.wb.wb_sel != wb_none);
  end

endmodule

// File: rtl/decode_queue.sv
// Elastic decoded-instruction queue between IF and EX, with a load-use
// interlock on the head entry and a single-cycle flush for redirects.
module decode_queue
  import rv32i_types::*;
#(
  parameter int DEPTH   = 4,
  parameter int ORDER_W = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  decode_queue_if.slave          bus,
  input  logic                   ex_load_valid,
  input  logic [4:0]             ex_load_rd,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_en_q;

  id_ex_stage_reg_t       mem_q [DEPTH];
  id_ex_stage_reg_t       enq_pkt;
  id_ex_stage_reg_t       head_pkt;
  logic [ORDER_W-1:0]     in_order;
  logic [ORDER_W_MAX-1:0] enq_order;
  logic                   head_valid;
  logic                   hazard;
  logic                   enq;
  logic                   deq;

  assign in_order  = bus.in_order;
  assign enq_order = ORDER_W_MAX'(in_order);

  rv32i_decoder u_decoder (
    .inst    (bus.in_inst),
    .pc      (bus.in_pc),
    .pc_next (bus.in_pc_next),
    .order   (enq_order),
    .pkt     (enq_pkt)
  );

  assign head_pkt   = mem_q[rptr_q];
  assign head_valid = (count_q != '0);

  // Load-use interlock: hold the head while EX's pending load targets one of its sources
  assign hazard = head_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                  ((ex_load_rd == head_pkt.rs1_s_s) || (ex_load_rd == head_pkt.rs2_s_s));

  assign bus.out_valid = head_valid && !hazard && !flush;
  assign bus.out_pkt   = bus.out_valid ? head_pkt : '0;
  assign bus.out_rs1_s = head_valid ? head_pkt.rs1_s_s : 5'd0;
  assign bus.out_rs2_s = head_valid ? head_pkt.rs2_s_s : 5'd0;
  assign bus.in_ready  = ready_en_q && (count_q != CNT_W'(DEPTH));
  assign count         = count_q;

  assign enq = bus.in_valid && bus.in_ready && !flush;
  assign deq = bus.out_valid && bus.out_ready;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
      wptr_d  = rptr_q;
    end else begin
      if (enq) wptr_d = wptr_q + 1'b1;
      if (deq) rptr_d = rptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

  // Storage is deliberately unreset; count gates every read of it
  always_ff @(posedge clk) begin
    if (enq) mem_q[wptr_q] <= enq_pkt;
  end

endmodule
